// File: rtl/crossing_pkg.sv
// Shared definitions for the level-crossing barrier: actuator state encoding
// and the gate command polarity also used by the crossing controller.
package crossing_pkg;

  typedef enum logic [2:0] {
    ST_OPEN     = 3'd0,
    ST_WARN     = 3'd1,
    ST_LOWERING = 3'd2,
    ST_CLOSED   = 3'd3,
    ST_RAISING  = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam logic CMD_CLOSE = 1'b1;
  localparam logic CMD_OPEN  = 1'b0;

endpackage

// File: rtl/crossing_gate_actuator_if.sv
// Barrier I/O bundle: controller command and limit switches in, motor, lamp
// and status out. The actuator is the slave side.
interface crossing_gate_actuator_if;
  logic gate_cmd;
  logic limit_down;
  logic limit_up;
  logic motor_down;
  logic motor_up;
  logic lamp_flash;
  logic gate_closed;
  logic gate_open;
  logic fault;

  modport master (
    output gate_cmd, limit_down, limit_up,
    input  motor_down, motor_up, lamp_flash, gate_closed, gate_open, fault
  );

  modport slave (
    input  gate_cmd, limit_down, limit_up,
    output motor_down, motor_up, lamp_flash, gate_closed, gate_open, fault
  );
endinterface

// File: rtl/crossing_phase_timer.sv
// Phase counter: cleared on request, otherwise counts up and saturates.
// terminal_o flags the last cycle of a phase of limit_i cycles.
module crossing_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != {CNT_W{1'b1}}) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/crossing_gate_actuator.sv
// Barrier actuator: warns, drives the motor toward the commanded limit,
// reports gate status and latches a fault on timeout or impossible limits.
module crossing_gate_actuator
  import crossing_pkg::*;
#(
  parameter int WARN_CYCLES   = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  crossing_gate_actuator_if.slave gate_if,
  output logic [CNT_W-1:0]      phase_cnt_o
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] phase_limit;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_done;
  logic             motor_down, motor_up, lamp_flash, gate_closed, gate_open, fault;

  assign phase_limit = (state_q == ST_WARN) ? CNT_W'(WARN_CYCLES) : CNT_W'(TRAVEL_CYCLES);

  crossing_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear_i   (state_d != state_q),
    .limit_i   (phase_limit),
    .count_o   (phase_cnt),
    .terminal_o(phase_done)
  );

  always_comb begin
    state_d = state_q;
    if ((state_q != ST_FAULT) && gate_if.limit_down && gate_if.limit_up) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_OPEN:     if (gate_if.gate_cmd == CMD_CLOSE) state_d = ST_WARN;
        ST_WARN: begin
          if (gate_if.gate_cmd == CMD_OPEN) state_d = ST_OPEN;
          else if (phase_done)              state_d = ST_LOWERING;
        end
        // A limit reached on the timeout cycle takes precedence over the fault.
        ST_LOWERING: begin
          if (gate_if.limit_down) state_d = ST_CLOSED;
          else if (phase_done)    state_d = ST_FAULT;
        end
        ST_CLOSED:   if (gate_if.gate_cmd == CMD_OPEN) state_d = ST_RAISING;
        ST_RAISING: begin
          if (gate_if.gate_cmd == CMD_CLOSE) state_d = ST_LOWERING;
          else if (gate_if.limit_up)         state_d = ST_OPEN;
          else if (phase_done)               state_d = ST_FAULT;
        end
        ST_FAULT:    state_d = ST_FAULT;
        default:     state_d = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    motor_down  = 1'b0;
    motor_up    = 1'b0;
    lamp_flash  = 1'b0;
    gate_closed = 1'b0;
    gate_open   = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_OPEN:     gate_open = 1'b1;
      ST_WARN:     lamp_flash = 1'b1;
      ST_LOWERING: begin lamp_flash = 1'b1; motor_down = 1'b1; end
      ST_CLOSED:   begin lamp_flash = 1'b1; gate_closed = 1'b1; end
      ST_RAISING:  begin lamp_flash = 1'b1; motor_up = 1'b1; end
      default:     begin lamp_flash = 1'b1; fault = 1'b1; end
    endcase
  end

  assign gate_if.motor_down  = motor_down;
  assign gate_if.motor_up    = motor_up;
  assign gate_if.lamp_flash  = lamp_flash;
  assign gate_if.gate_closed = gate_closed;
  assign gate_if.gate_open   = gate_open;
  assign gate_if.fault       = fault;
  assign phase_cnt_o         = phase_cnt;

endmodule

// File: tb/tb_crossing_gate_actuator.sv
// Bench for crossing_gate_actuator: directed vector table, multi-cycle corner
// sequences and a random run against a cycle-level behavioural model.
module tb_crossing_gate_actuator;

  localparam int WARN_CYCLES   = 4;
  localparam int TRAVEL_CYCLES = 8;
  localparam int CNT_W         = 8;

  // Expected output vectors {motor_down, motor_up, lamp_flash, gate_closed, gate_open, fault}
  localparam logic [5:0] O_OPEN   = 6'b000010;
  localparam logic [5:0] O_WARN   = 6'b001000;
  localparam logic [5:0] O_LOWER  = 6'b101000;
  localparam logic [5:0] O_CLOSED = 6'b001100;
  localparam logic [5:0] O_RAISE  = 6'b011000;
  localparam logic [5:0] O_FAULT  = 6'b001001;

  localparam int M_OPEN = 0, M_WARN = 1, M_DOWN = 2, M_SHUT = 3, M_UP = 4, M_FLT = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [CNT_W-1:0] phase_cnt;
  int               total = 0;
  int               bad = 0;
  int               m_phase;
  int               m_elapsed;

  crossing_gate_actuator_if gif ();

  crossing_gate_actuator #(
    .WARN_CYCLES  (WARN_CYCLES),
    .TRAVEL_CYCLES(TRAVEL_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gate_if    (gif.slave),
    .phase_cnt_o(phase_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cmd;
    logic       ld;
    logic       lu;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mkv(input logic c, input logic d, input logic u, input logic [5:0] e);
    vec_t v;
    v.cmd = c; v.ld = d; v.lu = u; v.exp = e;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {gif.motor_down, gif.motor_up, gif.lamp_flash, gif.gate_closed, gif.gate_open, gif.fault};
  endfunction

  function automatic logic [5:0] exp_of(input int ph);
    case (ph)
      M_OPEN:  return O_OPEN;
      M_WARN:  return O_WARN;
      M_DOWN:  return O_LOWER;
      M_SHUT:  return O_CLOSED;
      M_UP:    return O_RAISE;
      default: return O_FAULT;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic d, input logic u);
    gif.gate_cmd   = c;
    gif.limit_down = d;
    gif.limit_up   = u;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_for(input logic [5:0] target, input int budget, input string name);
    int n = 0;
    while (outs() !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(outs()), 32'(target));
  endtask

  task automatic count_to_fault(input string name);
    int n = 0;
    while (gif.fault !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'(TRAVEL_CYCLES));
  endtask

  // Behavioural model: phase plus cycles already spent in it, advanced once per
  // clock with the inputs that will be present at that clock edge.
  task automatic m_step(input logic c, input logic d, input logic u);
    int nxt = m_phase;
    if (m_phase != M_FLT && d && u) nxt = M_FLT;
    else if (m_phase == M_OPEN && c) nxt = M_WARN;
    else if (m_phase == M_WARN) begin
      if (!c) nxt = M_OPEN;
      else if (m_elapsed + 1 == WARN_CYCLES) nxt = M_DOWN;
    end else if (m_phase == M_DOWN) begin
      if (d) nxt = M_SHUT;
      else if (m_elapsed + 1 == TRAVEL_CYCLES) nxt = M_FLT;
    end else if (m_phase == M_SHUT && !c) nxt = M_UP;
    else if (m_phase == M_UP) begin
      if (c) nxt = M_DOWN;
      else if (u) nxt = M_OPEN;
      else if (m_elapsed + 1 == TRAVEL_CYCLES) nxt = M_FLT;
    end
    m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
    m_phase   = nxt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c;
    logic d;
    logic u;

    // Directed walk: close, raise, aborted warning, double-limit fault.
    tbl[0]  = mkv(1, 0, 0, O_WARN);
    tbl[1]  = mkv(1, 0, 0, O_WARN);
    tbl[2]  = mkv(1, 0, 0, O_WARN);
    tbl[3]  = mkv(1, 0, 0, O_WARN);
    tbl[4]  = mkv(1, 0, 0, O_LOWER);
    tbl[5]  = mkv(1, 0, 0, O_LOWER);
    tbl[6]  = mkv(1, 0, 0, O_LOWER);
    tbl[7]  = mkv(1, 1, 0, O_CLOSED);
    tbl[8]  = mkv(0, 1, 0, O_RAISE);
    tbl[9]  = mkv(0, 0, 0, O_RAISE);
    tbl[10] = mkv(0, 0, 0, O_RAISE);
    tbl[11] = mkv(0, 0, 1, O_OPEN);
    tbl[12] = mkv(0, 0, 1, O_OPEN);
    tbl[13] = mkv(1, 0, 0, O_WARN);
    tbl[14] = mkv(1, 0, 0, O_WARN);
    tbl[15] = mkv(0, 0, 0, O_OPEN);
    tbl[16] = mkv(0, 0, 0, O_OPEN);
    tbl[17] = mkv(0, 1, 1, O_FAULT);
    tbl[18] = mkv(1, 0, 0, O_FAULT);
    tbl[19] = mkv(0, 0, 0, O_FAULT);

    drive(1'b0, 1'b0, 1'b0);
    #1;
    check("reset_held_outs", 32'(outs()), 32'(O_OPEN));
    do_reset();
    check("reset_outs", 32'(outs()), 32'(O_OPEN));
    check("reset_cnt", 32'(phase_cnt), 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].cmd, tbl[i].ld, tbl[i].lu);
      @(negedge clk);
      $display("vec %0d cmd=%0b ld=%0b lu=%0b out=%06b", i, tbl[i].cmd, tbl[i].ld, tbl[i].lu, outs());
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Lowering timeout, sticky fault, recovery by reset.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    wait_for(O_LOWER, 10, "t4_reach_lower");
    count_to_fault("t4_timeout_cycles");
    check("t4_fault_outs", 32'(outs()), 32'(O_FAULT));
    for (int k = 0; k < 6; k++) begin
      gif.gate_cmd = k[0];
      @(negedge clk);
      check("t4_sticky", 32'(outs()), 32'(O_FAULT));
    end
    $display("seq timeout: fault held, resetting");
    do_reset();
    check("t4_after_reset", 32'(outs()), 32'(O_OPEN));

    // Reversal during raising restarts lowering with a fresh timeout.
    drive(1'b1, 1'b0, 1'b0);
    wait_for(O_LOWER, 10, "t5_reach_lower");
    gif.limit_down = 1'b1;
    @(negedge clk);
    check("t5_closed", 32'(outs()), 32'(O_CLOSED));
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_raise1", 32'(outs()), 32'(O_RAISE));
    @(negedge clk);
    check("t5_raise2", 32'(outs()), 32'(O_RAISE));
    gif.gate_cmd = 1'b1;
    @(negedge clk);
    check("t5_reverse", 32'(outs()), 32'(O_LOWER));
    check("t5_cnt_cleared", 32'(phase_cnt), 32'd0);
    count_to_fault("t5_fresh_timeout");
    $display("seq reversal: done");

    // Reset mid-lowering acts without waiting for a clock edge.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    wait_for(O_LOWER, 10, "t6_reach_lower");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_motor", 32'(gif.motor_down), 32'd0);
    check("t6_async_open", 32'(gif.gate_open), 32'd1);
    $display("seq async reset: done");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Random run against the model.
    do_reset();
    m_phase = M_OPEN;
    m_elapsed = 0;
    c = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (($urandom % 50 == 0) || (m_phase == M_FLT && m_elapsed > 4)) begin
        do_reset();
        m_phase = M_OPEN;
        m_elapsed = 0;
        c = 1'b0;
        check("rand_reset", 32'(outs()), 32'(O_OPEN));
        $display("rand %0d reset", it);
      end else begin
        if ($urandom % 6 == 0) c = ~c;
        d = ($urandom % 5 == 0);
        u = ($urandom % 5 == 0);
        drive(c, d, u);
        m_step(c, d, u);
        @(negedge clk);
        $display("rand %0d cmd=%0b ld=%0b lu=%0b out=%06b", it, c, d, u, outs());
        check("rand_outs", 32'(outs()), 32'(exp_of(m_phase)));
        check("rand_motor_excl", 32'(gif.motor_down & gif.motor_up), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
